gmsk_burst_sequencer: RTL and testbench

Sequences one GMSK transmit burst around the modulator: lead-in symbols, a payload of BURST_BITS symbols pulled from an upstream bit source, then guard symbols. It sits between the burst assembler (bit source) and the modulator/tx front end. It drives the modulator's symbol input and gates I/Q validity toward the RF chain. It also reports busy, completion and underrun status to the slot controller.

---
 rtl/gmsk_burst_sequencer.sv | 156 +++++++++++++++
 tb/tb_gmsk_burst_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gmsk_burst_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// gmsk_burst_sequencer : lead-in / payload / guard symbol sequencer for GMSK tx
// Revision 1.0
// ---------------------------------------------------------------------------
module gmsk_burst_sequencer #(
  parameter int LEAD_SYMBOLS  = 4,
  parameter int BURST_BITS    = 148,
  parameter int GUARD_SYMBOLS = 8,
  parameter bit DIFF_ENCODE   = 1'b1,
  parameter int CNT_WIDTH     = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic next_symbol_strobe,
  output logic current_symbol,
  input  logic fire,
  input  logic abort,
  input  logic bit_data,
  input  logic bit_valid,
  output logic bit_ready,
  output logic iq_gate,
  output logic busy,
  output logic burst_done,
  output logic underrun,
  input  logic clear_underrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LEAD    = 2'd1,
    PAYLOAD = 2'd2,
    GUARD   = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LEAD_LAST    = CNT_WIDTH'(LEAD_SYMBOLS - 1);
  localparam logic [CNT_WIDTH-1:0] PAYLOAD_LAST = CNT_WIDTH'(BURST_BITS - 1);
  localparam logic [CNT_WIDTH-1:0] GUARD_LAST   = CNT_WIDTH'(GUARD_SYMBOLS - 1);

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   counter_q, counter_d;
  logic                   strobe_q;
  logic                   prev_bit_q, prev_bit_d;
  logic                   symbol_q, symbol_d;
  logic                   iq_gate_q, iq_gate_d;
  logic                   done_q, done_d;
  logic                   underrun_q, underrun_d;
  logic                   underrun_set;
  logic                   bit_ready_c;
  logic                   sym_edge;
  logic                   payload_bit;

  assign sym_edge    = next_symbol_strobe & ~strobe_q;
  // A missing bit is transmitted as zero.
  assign payload_bit = bit_valid & bit_data;

  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    prev_bit_d   = prev_bit_q;
    symbol_d     = symbol_q;
    done_d       = 1'b0;
    underrun_set = 1'b0;
    bit_ready_c  = 1'b0;
    if (abort) begin
      state_d    = IDLE;
      counter_d  = '0;
      prev_bit_d = 1'b0;
      symbol_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          symbol_d = 1'b1;
          if (fire) begin
            state_d   = LEAD;
            counter_d = '0;
          end
        end
        LEAD: begin
          if (sym_edge) begin
            symbol_d = 1'b1;
            if (counter_q == LEAD_LAST) begin
              state_d   = PAYLOAD;
              counter_d = '0;
            end else begin
              counter_d = counter_q + 1'b1;
            end
          end
        end
        PAYLOAD: begin
          bit_ready_c = sym_edge;
          if (sym_edge) begin
            underrun_set = ~bit_valid;
            symbol_d     = DIFF_ENCODE ? (payload_bit ^ prev_bit_q) : payload_bit;
            prev_bit_d   = payload_bit;
            if (counter_q == PAYLOAD_LAST) begin
              state_d   = GUARD;
              counter_d = '0;
            end else begin
              counter_d = counter_q + 1'b1;
            end
          end
        end
        GUARD: begin
          if (sym_edge) begin
            symbol_d = 1'b1;
            if (counter_q == GUARD_LAST) begin
              state_d    = IDLE;
              counter_d  = '0;
              done_d     = 1'b1;
              prev_bit_d = 1'b0;
            end else begin
              counter_d = counter_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign iq_gate_d  = (state_q == PAYLOAD) | (state_q == GUARD);
  assign underrun_d = underrun_set | (underrun_q & ~clear_underrun);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      counter_q  <= '0;
      strobe_q   <= 1'b0;
      prev_bit_q <= 1'b0;
      symbol_q   <= 1'b1;
      iq_gate_q  <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      strobe_q   <= next_symbol_strobe;
      prev_bit_q <= prev_bit_d;
      symbol_q   <= symbol_d;
      iq_gate_q  <= iq_gate_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  assign current_symbol = symbol_q;
  assign bit_ready      = bit_ready_c;
  assign iq_gate        = iq_gate_q;
  assign busy           = (state_q != IDLE);
  assign burst_done     = done_q;
  assign underrun       = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_gmsk_burst_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_gmsk_burst_sequencer : directed bench, differential and raw instances
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_gmsk_burst_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, next_symbol_strobe, fire, abort, bit_data, bit_valid, clear_underrun;
  wire  current_symbol, bit_ready, iq_gate, busy, burst_done, underrun;
  wire  current_symbol_r, bit_ready_r, iq_gate_r, busy_r, burst_done_r, underrun_r;

  gmsk_burst_sequencer #(.DIFF_ENCODE(1'b1)) u_dut (
    .clock(clock), .reset(reset), .next_symbol_strobe(next_symbol_strobe),
    .current_symbol(current_symbol), .fire(fire), .abort(abort),
    .bit_data(bit_data), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .iq_gate(iq_gate), .busy(busy), .burst_done(burst_done),
    .underrun(underrun), .clear_underrun(clear_underrun));

  gmsk_burst_sequencer #(.DIFF_ENCODE(1'b0)) u_raw (
    .clock(clock), .reset(reset), .next_symbol_strobe(next_symbol_strobe),
    .current_symbol(current_symbol_r), .fire(fire), .abort(abort),
    .bit_data(bit_data), .bit_valid(bit_valid), .bit_ready(bit_ready_r),
    .iq_gate(iq_gate_r), .busy(busy_r), .burst_done(burst_done_r),
    .underrun(underrun_r), .clear_underrun(clear_underrun));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic br, iq, busy_pre, sym, sym_r, busy, done, und, br2, done2;
  } obs_t;

  typedef struct {
    bit zero_src;
    int uv_lo;
    int uv_hi;
    bit exp_und;
    int exp_br;
    int exp_iq;
  } row_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clock);
    #1;
  endtask

  function automatic bit pat(input int p);
    logic [4:0] v;
    v = 5'b01101;
    return v[p % 5];
  endfunction

  // One symbol interval: strobe high two clocks then low two clocks.
  task automatic sym(input bit v, input bit d, output obs_t o);
    next_symbol_strobe = 1'b1;
    bit_valid = v;
    bit_data  = d;
    #1;
    o.br = bit_ready; o.iq = iq_gate; o.busy_pre = busy;
    clk1();
    abort = 1'b0;
    clear_underrun = 1'b0;
    o.sym = current_symbol; o.sym_r = current_symbol_r;
    o.busy = busy; o.done = burst_done; o.und = underrun; o.br2 = bit_ready;
    clk1();
    o.done2 = burst_done;
    next_symbol_strobe = 1'b0;
    clk1();
    clk1();
  endtask

  // The fire cycle carries a strobe edge that must not be counted.
  task automatic start_burst();
    fire = 1'b1;
    next_symbol_strobe = 1'b1;
    clk1();
    fire = 1'b0;
    clk1();
    next_symbol_strobe = 1'b0;
    clk1();
    clk1();
  endtask

  task automatic run_burst(input row_t r, input int idx);
    obs_t o;
    bit v, d, b, prev, ed, er, pl;
    int brc, iqc, p;
    prev = 1'b0; brc = 0; iqc = 0;
    start_burst();
    for (int k = 0; k < 160; k++) begin
      pl = (k >= 4) && (k < 152);
      p  = k - 4;
      v  = 1'b1;
      d  = 1'b0;
      if (pl) begin
        v = !(p >= r.uv_lo && p <= r.uv_hi);
        d = r.zero_src ? 1'b0 : pat(p);
      end
      sym(v, d, o);
      if (pl) begin
        b = v & d; ed = b ^ prev; er = b; prev = b;
      end else begin
        ed = 1'b1; er = 1'b1;
      end
      if (o.br) brc++;
      if (o.iq) iqc++;
      chk($sformatf("row%0d k%0d bit_ready", idx, k), o.br, pl);
      chk($sformatf("row%0d k%0d bit_ready_width", idx, k), o.br2, 0);
      chk($sformatf("row%0d k%0d sym_diff", idx, k), o.sym, ed);
      chk($sformatf("row%0d k%0d sym_raw", idx, k), o.sym_r, er);
      chk($sformatf("row%0d k%0d busy", idx, k), o.busy_pre, 1);
      chk($sformatf("row%0d k%0d done", idx, k), o.done, (k == 159) ? 1 : 0);
      if (k == 159) begin
        chk($sformatf("row%0d busy_end", idx), o.busy, 0);
        chk($sformatf("row%0d done_pulse_width", idx), o.done2, 0);
      end
    end
    chk($sformatf("row%0d ready_count", idx), brc, r.exp_br);
    chk($sformatf("row%0d iq_symbols", idx), iqc, r.exp_iq);
    chk($sformatf("row%0d iq_gate_off", idx), iq_gate, 0);
    chk($sformatf("row%0d underrun", idx), underrun, r.exp_und);
  endtask

  row_t rows[3];
  obs_t o;
  int   brc;

  initial begin
    rows[0] = '{zero_src: 1'b0, uv_lo: -1, uv_hi: -1, exp_und: 1'b0, exp_br: 148, exp_iq: 156};
    rows[1] = '{zero_src: 1'b1, uv_lo: -1, uv_hi: -1, exp_und: 1'b0, exp_br: 148, exp_iq: 156};
    rows[2] = '{zero_src: 1'b0, uv_lo: 10, uv_hi: 12, exp_und: 1'b1, exp_br: 148, exp_iq: 156};

    reset = 1'b0; next_symbol_strobe = 1'b0; fire = 1'b0; abort = 1'b0;
    bit_data = 1'b0; bit_valid = 1'b0; clear_underrun = 1'b0;
    clk1(); clk1();
    chk("reset current_symbol", current_symbol, 1);
    chk("reset iq_gate", iq_gate, 0);
    chk("reset busy", busy, 0);
    chk("reset burst_done", burst_done, 0);
    chk("reset underrun", underrun, 0);
    chk("reset bit_ready", bit_ready, 0);
    reset = 1'b1;
    clk1();

    // Held strobe in LEAD, underrun set/clear priority, abort mid-payload.
    start_burst();
    sym(1'b1, 1'b1, o);
    chk("lead k0 bit_ready", o.br, 0);
    next_symbol_strobe = 1'b1;
    repeat (20) clk1();
    next_symbol_strobe = 1'b0;
    clk1(); clk1();
    sym(1'b1, 1'b1, o);
    chk("hold k2 bit_ready", o.br, 0);
    sym(1'b1, 1'b1, o);
    chk("hold k3 bit_ready", o.br, 0);
    sym(1'b1, 1'b1, o);
    chk("hold first payload bit_ready", o.br, 1);
    chk("first payload symbol", o.sym, 1);
    for (int p = 1; p < 50; p++) begin
      if (p == 20) begin
        clear_underrun = 1'b1;
        sym(1'b0, 1'b1, o);
        chk("underrun set beats clear", o.und, 1);
      end else if (p == 21) begin
        clear_underrun = 1'b1;
        sym(1'b1, 1'b1, o);
        chk("underrun cleared", o.und, 0);
      end else begin
        sym(1'b1, 1'b1, o);
      end
    end
    chk("pre-abort symbol", current_symbol, 0);
    abort = 1'b1;
    sym(1'b1, 1'b1, o);
    chk("abort bit_ready", o.br, 0);
    chk("abort busy", o.busy, 0);
    chk("abort current_symbol", o.sym, 1);
    chk("abort burst_done", o.done, 0);
    chk("abort burst_done later", o.done2, 0);
    sym(1'b1, 1'b1, o);
    chk("post-abort busy", o.busy_pre, 0);
    chk("post-abort done", o.done, 0);

    for (int i = 0; i < 3; i++) run_burst(rows[i], i);

    clear_underrun = 1'b1;
    clk1();
    clear_underrun = 1'b0;
    chk("clear after burst", underrun, 0);

    // abort together with fire in IDLE does nothing.
    abort = 1'b1; fire = 1'b1;
    clk1();
    abort = 1'b0; fire = 1'b0;
    chk("abort+fire idle busy", busy, 0);
    clk1();

    // fire held while busy, then reset mid-GUARD.
    start_burst();
    fire = 1'b1;
    brc = 0;
    for (int k = 0; k < 155; k++) begin
      sym(1'b1, pat(k), o);
      if (o.br) brc++;
    end
    chk("fire-while-busy ready_count", brc, 148);
    chk("fire-while-busy in guard busy", busy, 1);
    chk("fire-while-busy iq_gate", iq_gate, 1);
    reset = 1'b0;
    next_symbol_strobe = 1'b1;
    clk1();
    chk("midreset current_symbol", current_symbol, 1);
    chk("midreset iq_gate", iq_gate, 0);
    chk("midreset busy", busy, 0);
    chk("midreset burst_done", burst_done, 0);
    chk("midreset underrun", underrun, 0);
    reset = 1'b1; fire = 1'b0; next_symbol_strobe = 1'b0;
    clk1();
    for (int k = 0; k < 6; k++) begin
      sym(1'b1, 1'b1, o);
      chk($sformatf("post-reset k%0d busy", k), o.busy_pre, 0);
      chk($sformatf("post-reset k%0d done", k), o.done, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
